// File: rtl/stopwatch_pkg.sv
// Shared types, constants and helpers for the stopwatch time-keeping core.
// Default dividers assume a 100 MHz master clock.
package stopwatch_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MAX_COUNT = 6'd59;

  localparam int DEF_SEC_DIV    = 100_000_000;
  localparam int DEF_ADJ_DIV    = 50_000_000;
  localparam int DEF_BLINK_HALF = 25_000_000;
  localparam int DEF_SCAN_HALF  = 100_000;
  localparam int DEF_DB_CYCLES  = 1_000_000;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } run_state_t;

  // Register width able to hold 0..n-1 (at least one bit).
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Modulo-60 increment; anything at or above the limit lands on 0.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_COUNT) ? '0 : v + CNT_W'(1);
  endfunction

  // Out-of-range values are forced back to 0 whenever a field is rewritten.
  function automatic logic [CNT_W-1:0] sanitize(input logic [CNT_W-1:0] v);
    return (v > MAX_COUNT) ? '0 : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = width_for(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          synced;

  assign synced = sync[1];

  // The count only advances while the synchronized input disagrees with the
  // accepted level; any agreement restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= synced;
        pulse <= synced;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: mm:ss counters, run/pause, clear, adjust mode,
// plus the blink and display-scan square waves.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SEC_DIV    = DEF_SEC_DIV,
  parameter int ADJ_DIV    = DEF_ADJ_DIV,
  parameter int BLINK_HALF = DEF_BLINK_HALF,
  parameter int SCAN_HALF  = DEF_SCAN_HALF,
  parameter int DB_CYCLES  = DEF_DB_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             adj,
  input  logic             pause_btn,
  input  logic             clr_btn,
  output logic [CNT_W-1:0] mincounter,
  output logic [CNT_W-1:0] seccounter,
  output logic             blinkclk,
  output logic             fastclk
);

  localparam int SEC_W   = width_for(SEC_DIV);
  localparam int ADJ_W   = width_for(ADJ_DIV);
  localparam int BLINK_W = width_for(BLINK_HALF);
  localparam int SCAN_W  = width_for(SCAN_HALF);

  // ---------------- switch synchronizers ----------------
  logic [1:0] sel_sync;
  logic [1:0] adj_sync;
  logic       sel_s;
  logic       adj_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync <= '0;
      adj_sync <= '0;
    end else begin
      sel_sync <= {sel_sync[0], sel};
      adj_sync <= {adj_sync[0], adj};
    end
  end

  assign sel_s = sel_sync[1];
  assign adj_s = adj_sync[1];

  // ---------------- buttons: bit 0 = pause, bit 1 = clear ----------------
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic       pause_p;
  logic       clr_p;

  assign btn_raw = {clr_btn, pause_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[gi]),
      .level(),
      .pulse(btn_pulse[gi])
    );
  end

  assign pause_p = btn_pulse[0];
  assign clr_p   = btn_pulse[1];

  // ---------------- free-running prescalers ----------------
  logic [SEC_W-1:0]   sec_cnt;
  logic [ADJ_W-1:0]   adj_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               sec_tick;
  logic               adj_tick;
  logic               blink_wrap;
  logic               scan_wrap;

  assign sec_tick   = (sec_cnt == SEC_W'(SEC_DIV - 1));
  assign adj_tick   = (adj_cnt == ADJ_W'(ADJ_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_HALF - 1));
  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt   <= '0;
      adj_cnt   <= '0;
      blink_cnt <= '0;
      scan_cnt  <= '0;
      blinkclk  <= 1'b0;
      fastclk   <= 1'b0;
    end else begin
      sec_cnt   <= sec_tick   ? '0 : sec_cnt + SEC_W'(1);
      adj_cnt   <= adj_tick   ? '0 : adj_cnt + ADJ_W'(1);
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      scan_cnt  <= scan_wrap  ? '0 : scan_cnt + SCAN_W'(1);
      blinkclk  <= blinkclk ^ blink_wrap;
      fastclk   <= fastclk ^ scan_wrap;
    end
  end

  // ---------------- run/pause FSM ----------------
  run_state_t state;
  run_state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (pause_p) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
  end

  // ---------------- minute/second counters ----------------
  // Uses the pre-toggle state, so a tick coinciding with pause_p still lands.
  logic [CNT_W-1:0] min_next;
  logic [CNT_W-1:0] sec_next;

  always_comb begin
    min_next = mincounter;
    sec_next = seccounter;
    if (clr_p) begin
      min_next = '0;
      sec_next = '0;
    end else if (state == PAUSED) begin
      min_next = mincounter;
      sec_next = seccounter;
    end else if (!adj_s && sec_tick) begin
      if (seccounter >= MAX_COUNT) begin
        sec_next = '0;
        min_next = wrap_inc(mincounter);
      end else begin
        sec_next = seccounter + CNT_W'(1);
        min_next = sanitize(mincounter);
      end
    end else if (adj_s && adj_tick) begin
      // Adjust mode bumps one field only; no carry between fields.
      if (sel_s) begin
        sec_next = wrap_inc(seccounter);
        min_next = sanitize(mincounter);
      end else begin
        min_next = wrap_inc(mincounter);
        sec_next = sanitize(seccounter);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mincounter <= '0;
      seccounter <= '0;
    end else begin
      mincounter <= min_next;
      seccounter <= sec_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomized self-checking bench for stopwatch_counter with an arithmetic
// reference model and a few hand-computed scenario checks.
module tb_stopwatch_counter;

  localparam int SEC_DIV    = 10;
  localparam int ADJ_DIV    = 5;
  localparam int BLINK_HALF = 4;
  localparam int SCAN_HALF  = 2;
  localparam int DB         = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       adj = 1'b0;
  logic       pause_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic [5:0] mincounter;
  logic [5:0] seccounter;
  logic       blinkclk;
  logic       fastclk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(
    .SEC_DIV(SEC_DIV), .ADJ_DIV(ADJ_DIV), .BLINK_HALF(BLINK_HALF),
    .SCAN_HALF(SCAN_HALF), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .adj(adj),
    .pause_btn(pause_btn), .clr_btn(clr_btn),
    .mincounter(mincounter), .seccounter(seccounter),
    .blinkclk(blinkclk), .fastclk(fastclk)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts clock edges since reset release; every prescaler is a pure
  // function of it. Inputs reach the logic two edges after being sampled.
  int m_n = 0, m_min = 0, m_sec = 0;
  bit m_paused = 0;
  bit sel_h[2], adj_h[2], pb_h[2], cb_h[2];
  bit pb_lvl = 0, cb_lvl = 0, pb_pulse = 0, cb_pulse = 0;
  bit pb_q[$], cb_q[$];

  function automatic bit all_differ(input bit q[$], input bit lvl);
    if (q.size() < DB) return 0;
    foreach (q[i]) if (q[i] == lvl) return 0;
    return 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit sel_s, adj_s, tick_s, tick_a, was_pp, was_cp;
    int total;
    if (!rst_n) begin
      m_n = 0; m_min = 0; m_sec = 0; m_paused = 0;
      sel_h = '{0, 0}; adj_h = '{0, 0}; pb_h = '{0, 0}; cb_h = '{0, 0};
      pb_lvl = 0; cb_lvl = 0; pb_pulse = 0; cb_pulse = 0;
      pb_q.delete(); cb_q.delete();
    end else begin
      sel_s  = sel_h[1];
      adj_s  = adj_h[1];
      tick_s = (m_n % SEC_DIV) == SEC_DIV - 1;
      tick_a = (m_n % ADJ_DIV) == ADJ_DIV - 1;
      was_pp = pb_pulse;
      was_cp = cb_pulse;
      if (was_cp) begin
        m_min = 0; m_sec = 0;
      end else if (m_paused) begin
        m_min = m_min;
      end else if (!adj_s && tick_s) begin
        total = (m_min * 60 + m_sec + 1) % 3600;
        m_min = total / 60;
        m_sec = total % 60;
      end else if (adj_s && tick_a) begin
        if (sel_s) m_sec = (m_sec + 1) % 60;
        else       m_min = (m_min + 1) % 60;
      end
      if (was_pp) m_paused = !m_paused;
      // Debounce: accept a new level once the last DB synced samples all disagree.
      pb_q.push_back(pb_h[1]); if (pb_q.size() > DB) void'(pb_q.pop_front());
      cb_q.push_back(cb_h[1]); if (cb_q.size() > DB) void'(cb_q.pop_front());
      pb_pulse = 0; cb_pulse = 0;
      if (all_differ(pb_q, pb_lvl)) begin pb_lvl = !pb_lvl; pb_pulse = pb_lvl; end
      if (all_differ(cb_q, cb_lvl)) begin cb_lvl = !cb_lvl; cb_pulse = cb_lvl; end
      sel_h[1] = sel_h[0]; sel_h[0] = sel;
      adj_h[1] = adj_h[0]; adj_h[0] = adj;
      pb_h[1]  = pb_h[0];  pb_h[0]  = pause_btn;
      cb_h[1]  = cb_h[0];  cb_h[0]  = clr_btn;
      m_n++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model_min", int'(mincounter), m_min);
      check("model_sec", int'(seccounter), m_sec);
      check("model_blink", int'(blinkclk), (m_n / BLINK_HALF) % 2);
      check("model_fast", int'(fastclk), (m_n / SCAN_HALF) % 2);
    end
  end

  // ---------------- helpers ----------------
  function automatic int dut_time();
    return int'(mincounter) * 60 + int'(seccounter);
  endfunction

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic adjust_to(input bit field_sec, input int target);
    int guard = 0;
    adj = 1; sel = field_sec;
    while (((field_sec ? m_sec : m_min) != target) && guard < 1000) begin
      @(negedge clk); guard++;
    end
    check(field_sec ? "adjust_sec" : "adjust_min",
          field_sec ? int'(seccounter) : int'(mincounter), target);
  endtask

  task automatic wait_sec_phase(input int phase);
    int guard = 0;
    while ((m_n % SEC_DIV) != phase && guard < 40) begin @(negedge clk); guard++; end
    check("sec_phase_wait", m_n % SEC_DIV, phase);
  endtask

  task automatic press(output logic btn_unused, input int len);
    btn_unused = 1'b0;
    edges(len);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------
  initial begin : stim
    logic [7:0] blink_exp, fast_exp;
    int saved, guard, phold, chold;
    logic dummy;
    blink_exp = 8'b0111_1000;
    fast_exp  = 8'b0110_0110;

    edges(3);
    check("reset_min", int'(mincounter), 0);
    check("reset_sec", int'(seccounter), 0);
    check("reset_blink", int'(blinkclk), 0);
    check("reset_fast", int'(fastclk), 0);
    rst_n = 1;
    chk_en = 1;

    // Square waves and first 100 cycles of counting.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("blink_edge", int'(blinkclk), int'(blink_exp[i]));
      check("fast_edge", int'(fastclk), int'(fast_exp[i]));
    end
    edges(92);
    check("run100_sec", int'(seccounter), 10);
    check("run100_min", int'(mincounter), 0);
    $display("run 100 cycles: %0d:%0d", mincounter, seccounter);

    // 59:59 -> 00:00 on one sec_tick.
    adjust_to(1, 59);
    adjust_to(0, 59);
    adj = 0;
    edges(3);
    wait_sec_phase(0);
    check("wrap_5959_min", int'(mincounter), 0);
    check("wrap_5959_sec", int'(seccounter), 0);
    $display("59:59 rollover: %0d:%0d", mincounter, seccounter);

    // 00:59 -> 01:00.
    adjust_to(1, 59);
    adj = 0;
    edges(3);
    wait_sec_phase(0);
    check("carry_min", int'(mincounter), 1);
    check("carry_sec", int'(seccounter), 0);
    $display("00:59 carry: %0d:%0d", mincounter, seccounter);

    // Adjust seconds 58 -> 59 -> 00 with minutes held at 3.
    adjust_to(0, 3);
    adjust_to(1, 58);
    edges(1);
    guard = 0;
    while ((m_n % ADJ_DIV) != 0 && guard < 10) begin @(negedge clk); guard++; end
    check("adj59_sec", int'(seccounter), 59);
    check("adj59_min", int'(mincounter), 3);
    edges(1);
    guard = 0;
    while ((m_n % ADJ_DIV) != 0 && guard < 10) begin @(negedge clk); guard++; end
    check("adj00_sec", int'(seccounter), 0);
    check("adj00_min", int'(mincounter), 3);
    $display("adjust wrap: %0d:%0d", mincounter, seccounter);
    adj = 0;
    edges(4);

    // Bounced pause presses must not pause.
    foreach (blink_exp[i]) begin
      pause_btn = 1; edges((i % 2) + 1);
      pause_btn = 0; edges(1);
    end
    edges(6);
    saved = m_min * 60 + m_sec;
    edges(20);
    check("bounce_still_running", dut_time(), (saved + 2) % 3600);
    $display("bounced pause: %0d:%0d", mincounter, seccounter);

    // Stable press pauses; counters frozen 60 cycles.
    pause_btn = 1; edges(5); pause_btn = 0; edges(2);
    saved = m_min * 60 + m_sec;
    edges(60);
    check("paused_frozen", dut_time(), saved);
    $display("paused: %0d:%0d", mincounter, seccounter);

    // Second press resumes.
    pause_btn = 1; edges(5); pause_btn = 0;
    guard = 0;
    while (dut_time() != (saved + 1) % 3600 && guard < 15) begin @(negedge clk); guard++; end
    check("resume_count", dut_time(), (saved + 1) % 3600);
    $display("resumed: %0d:%0d after %0d cycles", mincounter, seccounter, guard);

    // Clear coinciding with a sec_tick at 12:34.
    adjust_to(0, 12);
    adjust_to(1, 30);
    adj = 0;
    guard = 0;
    while (!(m_min == 12 && m_sec == 34) && guard < 200) begin @(negedge clk); guard++; end
    wait_sec_phase(4);
    clr_btn = 1;
    edges(5);
    check("pre_clr_min", int'(mincounter), 12);
    check("pre_clr_sec", int'(seccounter), 34);
    edges(1);
    check("clr_min", int'(mincounter), 0);
    check("clr_sec", int'(seccounter), 0);
    clr_btn = 0;
    edges(10);
    check("clr_still_run_sec", int'(seccounter), 1);
    check("clr_still_run_min", int'(mincounter), 0);
    $display("clear at 12:34: %0d:%0d", mincounter, seccounter);

    // Asynchronous reset at 07:21.
    adjust_to(0, 7);
    adjust_to(1, 21);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("async_min", int'(mincounter), 0);
    check("async_sec", int'(seccounter), 0);
    check("async_blink", int'(blinkclk), 0);
    check("async_fast", int'(fastclk), 0);
    adj = 0; sel = 0;
    edges(2);
    rst_n = 1;
    edges(10);
    check("post_reset_sec", int'(seccounter), 1);
    check("post_reset_min", int'(mincounter), 0);
    $display("async reset: %0d:%0d", mincounter, seccounter);

    // Randomized phase.
    phold = 0; chold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
      if (phold > 0) phold--;
      else if ($urandom_range(0, 99) == 0) phold = $urandom_range(1, 8);
      if (chold > 0) chold--;
      else if ($urandom_range(0, 249) == 0) chold = $urandom_range(1, 8);
      pause_btn = (phold > 0);
      clr_btn   = (chold > 0);
    end
    press(dummy, 10);
    $display("random phase done: %0d:%0d", mincounter, seccounter);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
